traffic_light_monitor: RTL
==========================

Name: traffic_light_monitor

Overview:
Passive checker on the active-low RGB LED lines driven by the traffic light controller. It decodes the LED pattern into a phase and measures how long each phase is held. It checks the phase order (RED->GREEN->BLUE->RED) and each phase duration against expected cycle counts, and raises sticky error flags. It sits beside the controller on the same clock and feeds the debug/status logic.

Parameters:
RED_CYCLES, 200_000_000, expected RED hold length in clk cycles
GREEN_CYCLES, 110_000_000, expected GREEN hold length in clk cycles
BLUE_CYCLES, 60_000_001, expected BLUE hold length in clk cycles
TOL, 4, allowed absolute deviation in cycles, inclusive
CNT_W, 32, width of run counter and phase_len

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
led_red  in  1  red LED line, active-low (0 = lit)
led_green  in  1  green LED line, active-low
led_blue  in  1  blue LED line, active-low
err_clr  in  1  synchronous clear of sticky error flags
phase  out  2  current decoded phase: 0=OFF, 1=RED, 2=GREEN, 3=BLUE
locked  out  1  monitor is tracking a valid sequence
len_valid  out  1  one-cycle pulse when a phase ends
last_phase  out  2  code of the phase that just ended (valid with len_valid)
phase_len  out  CNT_W  cycles the ended phase was held (valid with len_valid)
cycles_done  out  16  count of completed RED->GREEN->BLUE->RED rounds; wraps
err_order  out  1  sticky: wrong transition, or OFF entered while locked
err_illegal  out  1  sticky: two or more lines low at once
err_timing  out  1  sticky: phase length outside EXP±TOL

Behaviour:
- Reset (async, rst_n=0): sample register = 3'b111 (OFF); phase=0; run_cnt=0; locked=0; len_valid=0; last_phase=0; phase_len=0; cycles_done=0; all err_* = 0.
- Stage 1: LED lines registered each clk. Decode: exactly one line low gives RED, GREEN or BLUE; all high gives OFF; two or more low gives ILLEGAL. phase updates 1 cycle after the input changes. An ILLEGAL pattern shows as phase=0.
- Run counter: increments each cycle the decoded pattern is unchanged and saturates at 2^CNT_W-1. On the first cycle of a new pattern, run_cnt is loaded with 1.
- Pattern change X->Y: one-cycle len_valid pulse, with last_phase=X and phase_len=run_cnt (exact hold length of X). This happens for every change, including ones to or from OFF.
- FSM UNLOCKED: go to LOCKED on any transition into RED. The partial phase before lock is never timing-checked.
- FSM LOCKED, legal transitions: RED->GREEN, GREEN->BLUE, BLUE->RED. On each, if |phase_len - EXP_X| > TOL, set err_timing. On BLUE->RED, cycles_done += 1.
- FSM LOCKED, other transitions: any other transition, including to OFF, sets err_order and returns to UNLOCKED. A direct BLUE->RED that also re-locks stays LOCKED.
- ILLEGAL in any state: sets err_illegal and forces UNLOCKED. The phase that follows ILLEGAL is not timing-checked.
- Saturated run_cnt at a legal transition always fails the timing check.
- err_clr: clears all err_* on the next edge. If an error event occurs in the same cycle as err_clr, the event wins and the flag stays 1.
- locked output = (FSM == LOCKED), registered.
- Subtraction for the tolerance check is done at CNT_W+1 bits, so there is no wrap.

Optional Feature:
TLM_SYNC_EN: when defined, a 2-flop synchronizer (reset to 1) is inserted ahead of stage 1 on each LED line, so the lines may come from another clock domain. Latency input->phase becomes 3 cycles; measured lengths are unchanged. When not defined, the lines are sampled directly and latency is 1 cycle.

Test Plan:
1. RED=20, GREEN=11, BLUE=6, TOL=0. Drive RED 20 / GREEN 11 / BLUE 6 cycles, 3 rounds -> lengths 20/11/6 reported; cycles_done=2 after the 3rd red entry (first red pre-lock); no errors; locked=1.
2. Same parameters, GREEN held 13 cycles -> phase_len=13 at GREEN->BLUE; err_timing=1; err_order=0; locked remains 1.
3. RED->BLUE transition while locked -> err_order=1; locked=0. Next BLUE->RED re-locks; subsequent clean round has no new timing error.
4. Drive red=0 and green=0 together for 1 cycle -> err_illegal=1; phase=0; locked=0. Pulse err_clr -> all flags 0 next cycle.
5. Assert rst_n=0 mid-GREEN, release -> all outputs 0 immediately on assertion; first RED after release sets locked=1.
6. err_clr asserted in the same cycle as an order violation -> err_order=1 after the edge.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Passive checker for the active-low RGB traffic light lines: phase decode, hold-length
// measurement, order/timing/illegal-pattern flags. Optional TLM_SYNC_EN adds a 2-flop input synchronizer.
module traffic_light_monitor #(
    parameter int unsigned RED_CYCLES   = 200_000_000,
    parameter int unsigned GREEN_CYCLES = 110_000_000,
    parameter int unsigned BLUE_CYCLES  = 60_000_001,
    parameter int unsigned TOL          = 4,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             led_red,
    input  logic             led_green,
    input  logic             led_blue,
    input  logic             err_clr,
    output logic [1:0]       phase,
    output logic             locked,
    output logic             len_valid,
    output logic [1:0]       last_phase,
    output logic [CNT_W-1:0] phase_len,
    output logic [15:0]      cycles_done,
    output logic             err_order,
    output logic             err_illegal,
    output logic             err_timing
);

    localparam int unsigned DW = CNT_W + 1;

    localparam logic [2:0] P_OFF   = 3'd0;
    localparam logic [2:0] P_RED   = 3'd1;
    localparam logic [2:0] P_GREEN = 3'd2;
    localparam logic [2:0] P_BLUE  = 3'd3;
    localparam logic [2:0] P_ILL   = 3'd4;

    localparam logic [0:0] S_UNLOCKED = 1'b0;
    localparam logic [0:0] S_LOCKED   = 1'b1;

    // Lines are {red, green, blue}, active-low.
    function automatic logic [2:0] decode(input logic [2:0] l);
        case (l)
            3'b111:  decode = P_OFF;
            3'b011:  decode = P_RED;
            3'b101:  decode = P_GREEN;
            3'b110:  decode = P_BLUE;
            default: decode = P_ILL;
        endcase
    endfunction

    function automatic logic [1:0] to_code(input logic [2:0] p);
        to_code = (p == P_ILL) ? 2'd0 : p[1:0];
    endfunction

    logic [2:0]       lines_in;
    logic [2:0]       samp_q;
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] run_cnt;
    logic             skip_q;

`ifdef TLM_SYNC_EN
    logic [2:0] sync1_q, sync2_q;

    // Two-flop synchronizer, idles at OFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 3'b111;
            sync2_q <= 3'b111;
        end else begin
            sync1_q <= {led_red, led_green, led_blue};
            sync2_q <= sync1_q;
        end
    end

    assign lines_in = sync2_q;
`else
    assign lines_in = {led_red, led_green, led_blue};
`endif

    logic [2:0]       pat_in, pat_q;
    logic             chg, legal, sat, timing_bad;
    logic             order_evt, illegal_evt, timing_evt, round_evt;
    logic [CNT_W-1:0] exp_len;
    logic [DW-1:0]    diff, abs_diff;

    assign pat_in = decode(lines_in);
    assign pat_q  = decode(samp_q);
    assign chg    = (pat_in != pat_q);
    assign sat    = &run_cnt;
    assign legal  = ((pat_q == P_RED)   && (pat_in == P_GREEN)) ||
                    ((pat_q == P_GREEN) && (pat_in == P_BLUE))  ||
                    ((pat_q == P_BLUE)  && (pat_in == P_RED));

    // Tolerance check on the ending phase, one bit wider so the difference cannot wrap.
    always_comb begin
        exp_len = '0;
        case (pat_q)
            P_RED:   exp_len = CNT_W'(RED_CYCLES);
            P_GREEN: exp_len = CNT_W'(GREEN_CYCLES);
            P_BLUE:  exp_len = CNT_W'(BLUE_CYCLES);
            default: exp_len = '0;
        endcase
        diff       = {1'b0, run_cnt} - {1'b0, exp_len};
        abs_diff   = diff[DW-1] ? (~diff + DW'(1)) : diff;
        timing_bad = sat || (abs_diff > DW'(TOL));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_UNLOCKED;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        order_evt   = 1'b0;
        timing_evt  = 1'b0;
        round_evt   = 1'b0;
        illegal_evt = (pat_in == P_ILL);
        if (illegal_evt) begin
            state_d = S_UNLOCKED;
        end else if (chg) begin
            if (state_q == S_UNLOCKED) begin
                if (pat_in == P_RED) state_d = S_LOCKED;
            end else if (legal) begin
                timing_evt = timing_bad && !skip_q;
                round_evt  = (pat_q == P_BLUE);
            end else begin
                order_evt = 1'b1;
                state_d   = S_UNLOCKED;
            end
        end
    end

    assign locked = (state_q == S_LOCKED);

    // Sample register, run counter, length report and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q      <= 3'b111;
            phase       <= 2'd0;
            run_cnt     <= '0;
            skip_q      <= 1'b0;
            len_valid   <= 1'b0;
            last_phase  <= 2'd0;
            phase_len   <= '0;
            cycles_done <= 16'd0;
            err_order   <= 1'b0;
            err_illegal <= 1'b0;
            err_timing  <= 1'b0;
        end else begin
            samp_q    <= lines_in;
            phase     <= to_code(pat_in);
            len_valid <= chg;
            if (chg) begin
                run_cnt    <= CNT_W'(1);
                skip_q     <= (pat_q == P_ILL);
                last_phase <= to_code(pat_q);
                phase_len  <= run_cnt;
            end else if (!sat) begin
                run_cnt <= run_cnt + CNT_W'(1);
            end
            if (round_evt) cycles_done <= cycles_done + 16'd1;
            err_order   <= (err_order   & ~err_clr) | order_evt;
            err_illegal <= (err_illegal & ~err_clr) | illegal_evt;
            err_timing  <= (err_timing  & ~err_clr) | timing_evt;
        end
    end

endmodule
